dcache_tlb: RTL and testbench
=============================

DCACHE_TLB -- requirements
Module: dcache_tlb

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clock and reset_n.
REQ-002 The module SHALL have parameter OFFSET, default 12, meaning page-offset bit count.
REQ-003 The module SHALL have parameter PHYS_ADDR_SIZE, default 24, meaning physical address width.
REQ-004 The module SHALL have parameter TLB_ENTRIES, default 4, meaning fully-associative TLB entries.
REQ-005 The module SHALL have parameter LINES, default 16, meaning direct-mapped lines of 128 bits (16 bytes).
REQ-006 The module SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, clock
- reset_n, in, 1, async active-low reset
- access_i, in, 1, load or store request; exception already masked
- write_i, in, 1, 1 = store, 0 = load
- word_i, in, 1, 1 = 32-bit access, 0 = byte access
- virtual_address_i, in, 32, access address
- write_data_i, in, 32, store data
- privilege_i, in, 1, 1 = kernel, bypass translation
- tlb_w_virtual_page_i, in, 32-OFFSET, TLB write tag
- tlb_w_phys_page_i, in, PHYS_ADDR_SIZE-OFFSET, TLB write frame
- tlb_write_enable_i, in, 1, TLB install strobe
- fill_valid_i, in, 1, memory line return
- fill_line_i, in, 128, returned line
- phys_address_o, out, PHYS_ADDR_SIZE, translated address
- tlb_miss_o, out, 1, translation miss
- ready_o, out, 1, translation valid
- miss_o, out, 1, cache miss
- read_data_o, out, 32, load data
- dirty_evict_o, out, 1, victim dirty on miss
- evict_line_o, out, 128, victim line
- evict_addr_o, out, PHYS_ADDR_SIZE, victim line base address

Function
REQ-007 Translation SHALL be combinational: privilege_i=1 gives phys = virtual_address_i[PHYS_ADDR_SIZE-1:0], ready_o=1, tlb_miss_o=0.
REQ-008 With privilege_i=0, a valid-entry tag match SHALL give phys = {frame, offset}, ready_o=1; no match with access_i=1 SHALL give tlb_miss_o=1, ready_o=0.
REQ-009 With access_i=0, tlb_miss_o, miss_o, dirty_evict_o and ready_o SHALL be 0.
REQ-010 A TLB write SHALL occur at the clock edge; an existing matching tag SHALL be overwritten, otherwise the entry at a round-robin pointer SHALL be written and the pointer SHALL advance, wrapping at TLB_ENTRIES-1.
REQ-011 The cache SHALL split the physical address into byte[3:0], index[log2(LINES)+3:4] and tag (the remaining upper bits).
REQ-012 A hit SHALL require ready_o=1, a valid line and an equal tag; miss_o = access_i & ready_o & ~hit.
REQ-013 On a load hit, read_data_o SHALL return the addressed word combinationally (address bits [3:2]); on a load miss it SHALL return 0.
REQ-014 On a store hit, the addressed word SHALL be written at the clock edge and the line's dirty bit SHALL be set; a store miss SHALL write nothing.
REQ-015 On a miss, dirty_evict_o SHALL equal victim valid & dirty, and evict_line_o/evict_addr_o SHALL present the victim line and {victim tag, index, 4'b0}.
REQ-016 fill_valid_i with miss_o=1 SHALL write fill_line_i, tag and valid=1 and clear dirty at the edge, so the same access hits next cycle; fill_valid_i without a miss SHALL be ignored.
REQ-017 A TLB write in the same cycle as an access SHALL not affect that cycle's translation.

Reset
REQ-018 Asserting reset_n low SHALL immediately clear all TLB valid bits, the round-robin pointer, and all cache valid and dirty bits, including mid-access; data arrays are not reset.
REQ-019 After reset with privilege_i=0, every access SHALL report tlb_miss_o=1, and kernel accesses SHALL report miss_o=1.

Configuration
REQ-020 With macro DCACHE_BYTE_ACCESS_EN defined, word_i=0 loads SHALL return the zero-extended addressed byte and word_i=0 stores SHALL write only byte write_data_i[7:0].
REQ-021 Without DCACHE_BYTE_ACCESS_EN, word_i SHALL be ignored and all accesses SHALL be word accesses.

Verification
REQ-022 After reset, user load at 0x00001004 -> tlb_miss_o=1, ready_o=0; install page 0x00001 -> frame 0x005; retry -> phys_address_o=0x005004, miss_o=1.
REQ-023 Fill line {32'hD,32'hC,32'hB,32'hA} at 0x005000 -> next-cycle load 0x00001004 -> miss_o=0, read_data_o=0x0000000B.
REQ-024 Store 0xCAFEBABE to 0x00001008 -> load reads 0xCAFEBABE; kernel access to 0x015000 (same index) -> dirty_evict_o=1, evict_addr_o=0x005000, evict_line_o[95:64]=0xCAFEBABE.
REQ-025 Install 5 distinct pages with TLB_ENTRIES=4 -> the first page misses and the other four hit.
REQ-026 With DCACHE_BYTE_ACCESS_EN, byte store 0x7F to 0x00001005 -> word load 0x00001004 reads 0x00007F0B; byte load 0x00001005 reads 0x0000007F.
REQ-027 Assert reset_n mid-sequence -> miss_o=1 and tlb_miss_o=1 on the next accesses.

Source files
------------

// File: rtl/dcache_tlb.sv
// Data cache front end: fully-associative TLB feeding a direct-mapped, write-back line cache.
// Optional byte-granular loads/stores are enabled by defining DCACHE_BYTE_ACCESS_EN.
module dcache_tlb #(
  parameter int OFFSET         = 12,
  parameter int PHYS_ADDR_SIZE = 24,
  parameter int TLB_ENTRIES    = 4,
  parameter int LINES          = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             access_i,
  input  logic                             write_i,
  input  logic                             word_i,
  input  logic [31:0]                      virtual_address_i,
  input  logic [31:0]                      write_data_i,
  input  logic                             privilege_i,
  input  logic [32-OFFSET-1:0]             tlb_w_virtual_page_i,
  input  logic [PHYS_ADDR_SIZE-OFFSET-1:0] tlb_w_phys_page_i,
  input  logic                             tlb_write_enable_i,
  input  logic                             fill_valid_i,
  input  logic [127:0]                     fill_line_i,
  output logic [PHYS_ADDR_SIZE-1:0]        phys_address_o,
  output logic                             tlb_miss_o,
  output logic                             ready_o,
  output logic                             miss_o,
  output logic [31:0]                      read_data_o,
  output logic                             dirty_evict_o,
  output logic [127:0]                     evict_line_o,
  output logic [PHYS_ADDR_SIZE-1:0]        evict_addr_o
);

  localparam int VPN_W = 32 - OFFSET;
  localparam int PPN_W = PHYS_ADDR_SIZE - OFFSET;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = PHYS_ADDR_SIZE - IDX_W - 4;
  localparam int PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

`ifdef DCACHE_BYTE_ACCESS_EN
  localparam logic BYTE_EN = 1'b1;
`else
  localparam logic BYTE_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- TLB
  logic [TLB_ENTRIES-1:0] tlb_valid;
  logic [VPN_W-1:0]       tlb_vpn [TLB_ENTRIES];
  logic [PPN_W-1:0]       tlb_ppn [TLB_ENTRIES];
  logic [PTR_W-1:0]       rr_ptr;

  logic             tlb_hit;
  logic [PPN_W-1:0] hit_ppn;
  logic             w_match;
  logic [PTR_W-1:0] w_slot;
  logic [PTR_W-1:0] wr_slot;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tlb_hit = 1'b0;
    hit_ppn = '0;
    w_match = 1'b0;
    w_slot  = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (tlb_valid[i] && tlb_vpn[i] == virtual_address_i[31:OFFSET]) begin
        tlb_hit = 1'b1;
        hit_ppn = tlb_ppn[i];
      end
      if (tlb_valid[i] && tlb_vpn[i] == tlb_w_virtual_page_i) begin
        w_match = 1'b1;
        w_slot  = PTR_W'(i);
      end
    end
  end

  // A rewrite of an already-mapped page replaces that entry in place.
  assign wr_slot = w_match ? w_slot : rr_ptr;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tlb_valid <= '0;
      rr_ptr    <= '0;
    end else if (tlb_write_enable_i) begin
      tlb_valid[wr_slot] <= 1'b1;
      if (!w_match)
        rr_ptr <= (rr_ptr == PTR_W'(TLB_ENTRIES - 1)) ? '0 : rr_ptr + PTR_W'(1);
    end
  end

  // NOTE: tag/data storage is deliberately not reset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (tlb_write_enable_i) begin
      tlb_vpn[wr_slot] <= tlb_w_virtual_page_i;
      tlb_ppn[wr_slot] <= tlb_w_phys_page_i;
    end
  end

  always_comb begin
    phys_address_o = '0;
    if (privilege_i)
      phys_address_o = virtual_address_i[PHYS_ADDR_SIZE-1:0];
    else if (tlb_hit)
      phys_address_o = {hit_ppn, virtual_address_i[OFFSET-1:0]};
  end

  assign ready_o    = access_i & (privilege_i | tlb_hit);
  assign tlb_miss_o = access_i & ~privilege_i & ~tlb_hit;

  // -------------------------------------------------------------- cache
  logic [LINES-1:0] line_valid;
  logic [LINES-1:0] line_dirty;
  logic [TAG_W-1:0] line_tag  [LINES];
  logic [127:0]     line_data [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word_sel;
  logic [1:0]       byte_sel;
  logic [127:0]     victim;
  logic [31:0]      cur_word;
  logic [7:0]       cur_byte;
  logic [31:0]      st_word;
  logic             hit;
  logic             byte_mode;
  logic             store_hit;
  logic             fill_en;

  assign idx      = phys_address_o[IDX_W+3:4];
  assign tag      = phys_address_o[PHYS_ADDR_SIZE-1:IDX_W+4];
  assign word_sel = phys_address_o[3:2];
  assign byte_sel = phys_address_o[1:0];

  assign victim   = line_data[idx];
  assign cur_word = victim[{word_sel, 5'b0} +: 32];
  assign cur_byte = cur_word[{byte_sel, 3'b0} +: 8];

  assign byte_mode = BYTE_EN & ~word_i;
  assign hit       = ready_o & line_valid[idx] & (line_tag[idx] == tag);
  assign miss_o    = access_i & ready_o & ~hit;
  assign store_hit = hit & write_i;
  assign fill_en   = fill_valid_i & miss_o;

  always_comb begin
    st_word = write_data_i;
    if (byte_mode) begin
      st_word = cur_word;
      st_word[{byte_sel, 3'b0} +: 8] = write_data_i[7:0];
    end
  end

  always_comb begin
    read_data_o = '0;
    if (hit && !write_i)
      read_data_o = byte_mode ? {24'b0, cur_byte} : cur_word;
  end

  assign dirty_evict_o = miss_o & line_valid[idx] & line_dirty[idx];
  assign evict_line_o  = victim;
  assign evict_addr_o  = {line_tag[idx], idx, 4'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_valid <= '0;
      line_dirty <= '0;
    end else if (fill_en) begin
      line_valid[idx] <= 1'b1;
      line_dirty[idx] <= 1'b0;
    end else if (store_hit) begin
      line_dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_data[idx] <= fill_line_i;
      line_tag[idx]  <= tag;
    end else if (store_hit) begin
      line_data[idx][{word_sel, 5'b0} +: 32] <= st_word;
    end
  end

endmodule

// File: tb/tb_dcache_tlb.sv
// Self-checking bench for dcache_tlb: directed scenarios plus randomized traffic
// compared every cycle against a behavioural TLB/cache model.
module tb_dcache_tlb;

  localparam int OFFSET = 12;
  localparam int PAS    = 24;
  localparam int NTLB   = 4;
  localparam int LINES  = 16;

`ifdef DCACHE_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          access_i = 1'b0, write_i = 1'b0, word_i = 1'b1, privilege_i = 1'b0;
  logic [31:0]   virtual_address_i = '0, write_data_i = '0;
  logic [19:0]   tlb_w_virtual_page_i = '0;
  logic [11:0]   tlb_w_phys_page_i = '0;
  logic          tlb_write_enable_i = 1'b0, fill_valid_i = 1'b0;
  logic [127:0]  fill_line_i = '0;
  logic [23:0]   phys_address_o, evict_addr_o;
  logic          tlb_miss_o, ready_o, miss_o, dirty_evict_o;
  logic [31:0]   read_data_o;
  logic [127:0]  evict_line_o;

  dcache_tlb #(.OFFSET(OFFSET), .PHYS_ADDR_SIZE(PAS), .TLB_ENTRIES(NTLB), .LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n), .access_i(access_i), .write_i(write_i), .word_i(word_i),
    .virtual_address_i(virtual_address_i), .write_data_i(write_data_i), .privilege_i(privilege_i),
    .tlb_w_virtual_page_i(tlb_w_virtual_page_i), .tlb_w_phys_page_i(tlb_w_phys_page_i),
    .tlb_write_enable_i(tlb_write_enable_i), .fill_valid_i(fill_valid_i), .fill_line_i(fill_line_i),
    .phys_address_o(phys_address_o), .tlb_miss_o(tlb_miss_o), .ready_o(ready_o), .miss_o(miss_o),
    .read_data_o(read_data_o), .dirty_evict_o(dirty_evict_o), .evict_line_o(evict_line_o),
    .evict_addr_o(evict_addr_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: TLB as slot table + replacement counter, cache as per-index word arrays.
  bit        m_tv [NTLB];
  bit [19:0] m_tvp[NTLB];
  bit [11:0] m_tpp[NTLB];
  int        m_ptr;
  bit        m_cv [LINES];
  bit        m_cd [LINES];
  bit [15:0] m_ct [LINES];
  bit [31:0] m_cw [LINES][4];

  bit        e_thit, e_ready, e_tmiss, e_chit, e_miss, e_de, e_bytem, e_found;
  bit [11:0] e_frame;
  bit [23:0] e_pa;
  int        e_idx, e_w, e_b, e_slot;
  bit [31:0] e_rd;

  always @(negedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NTLB; i++) m_tv[i] = 1'b0;
      for (int i = 0; i < LINES; i++) begin m_cv[i] = 1'b0; m_cd[i] = 1'b0; end
      m_ptr = 0;
    end
    e_thit = 1'b0; e_frame = '0;
    for (int i = 0; i < NTLB; i++)
      if (m_tv[i] && m_tvp[i] == virtual_address_i[31:12]) begin e_thit = 1'b1; e_frame = m_tpp[i]; end
    e_ready = access_i && (privilege_i || e_thit);
    e_tmiss = access_i && !privilege_i && !e_thit;
    e_pa    = privilege_i ? virtual_address_i[23:0] : {e_frame, virtual_address_i[11:0]};
    e_idx   = (e_pa / 16) % LINES;
    e_w     = (e_pa / 4) % 4;
    e_b     = e_pa % 4;
    e_chit  = e_ready && m_cv[e_idx] && m_ct[e_idx] == e_pa[23:8];
    e_miss  = e_ready && !e_chit;
    e_de    = e_miss && m_cv[e_idx] && m_cd[e_idx];
    e_bytem = BYTE_EN && !word_i;
    e_rd    = '0;
    if (access_i && !write_i && e_chit)
      e_rd = e_bytem ? ((m_cw[e_idx][e_w] >> (8 * e_b)) & 32'hFF) : m_cw[e_idx][e_w];

    check("tlb_miss", tlb_miss_o, e_tmiss);
    check("ready", ready_o, e_ready);
    check("miss", miss_o, e_miss);
    check("dirty_evict", dirty_evict_o, e_de);
    if (e_ready) check("phys_address", phys_address_o, e_pa);
    if (access_i && !write_i) check("read_data", read_data_o, e_rd);
    if (e_miss && m_cv[e_idx]) begin
      check("evict_addr", evict_addr_o, {m_ct[e_idx], 4'(e_idx), 4'b0});
      check("evict_line", evict_line_o,
            {m_cw[e_idx][3], m_cw[e_idx][2], m_cw[e_idx][1], m_cw[e_idx][0]});
    end

    if (reset_n) begin
      if (tlb_write_enable_i) begin
        e_found = 1'b0; e_slot = m_ptr;
        for (int i = 0; i < NTLB; i++)
          if (m_tv[i] && m_tvp[i] == tlb_w_virtual_page_i) begin e_found = 1'b1; e_slot = i; end
        m_tv[e_slot] = 1'b1; m_tvp[e_slot] = tlb_w_virtual_page_i; m_tpp[e_slot] = tlb_w_phys_page_i;
        if (!e_found) m_ptr = (m_ptr + 1) % NTLB;
      end
      if (access_i && write_i && e_chit) begin
        if (e_bytem) m_cw[e_idx][e_w][8 * e_b +: 8] = write_data_i[7:0];
        else         m_cw[e_idx][e_w] = write_data_i;
        m_cd[e_idx] = 1'b1;
      end
      if (fill_valid_i && e_miss) begin
        for (int k = 0; k < 4; k++) m_cw[e_idx][k] = fill_line_i[32 * k +: 32];
        m_ct[e_idx] = e_pa[23:8];
        m_cv[e_idx] = 1'b1;
        m_cd[e_idx] = 1'b0;
      end
    end
  end

  // Each helper drives just after a rising edge and returns just after the following falling edge.
  task automatic op(input bit acc, input bit wr, input bit wd, input bit pr,
                    input logic [31:0] va, input logic [31:0] wdat,
                    input bit fv = 1'b0, input logic [127:0] fl = '0);
    @(posedge clock); #1;
    access_i = acc; write_i = wr; word_i = wd; privilege_i = pr;
    virtual_address_i = va; write_data_i = wdat;
    tlb_write_enable_i = 1'b0; fill_valid_i = fv; fill_line_i = fl;
    @(negedge clock); #1;
  endtask

  task automatic tlb_install(input logic [19:0] vp, input logic [11:0] pp);
    @(posedge clock); #1;
    access_i = 1'b0; fill_valid_i = 1'b0;
    tlb_write_enable_i = 1'b1; tlb_w_virtual_page_i = vp; tlb_w_phys_page_i = pp;
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    do_reset();

    op(1, 0, 1, 0, 32'h0000_1004, '0);
    check("reset_user_tlb_miss", tlb_miss_o, 1'b1);
    check("reset_user_ready", ready_o, 1'b0);
    op(1, 0, 1, 1, 32'h0000_5000, '0);
    check("reset_kernel_miss", miss_o, 1'b1);

    tlb_install(20'h00001, 12'h005);
    op(1, 0, 1, 0, 32'h0000_1004, '0, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA});
    check("xlate_phys", phys_address_o, 24'h005004);
    check("xlate_miss", miss_o, 1'b1);
    check("xlate_tlb_miss", tlb_miss_o, 1'b0);
    op(1, 0, 1, 0, 32'h0000_1004, '0);
    check("fill_hit_miss", miss_o, 1'b0);
    check("fill_hit_data", read_data_o, 32'h0000_000B);

    op(1, 1, 1, 0, 32'h0000_1008, 32'hCAFE_BABE);
    check("store_hit_miss", miss_o, 1'b0);
    op(1, 0, 1, 0, 32'h0000_1008, '0);
    check("store_readback", read_data_o, 32'hCAFE_BABE);
    op(1, 0, 1, 1, 32'h0001_5000, '0);
    check("evict_miss", miss_o, 1'b1);
    check("evict_dirty", dirty_evict_o, 1'b1);
    check("evict_addr_lit", evict_addr_o, 24'h005000);
    check("evict_word2", evict_line_o[95:64], 32'hCAFE_BABE);

`ifdef DCACHE_BYTE_ACCESS_EN
    op(1, 1, 0, 0, 32'h0000_1005, 32'h0000_007F);
    op(1, 0, 1, 0, 32'h0000_1004, '0);
    check("byte_store_word", read_data_o, 32'h0000_7F0B);
    op(1, 0, 0, 0, 32'h0000_1005, '0);
    check("byte_load", read_data_o, 32'h0000_007F);
`endif

    for (int k = 0; k < 5; k++) tlb_install(20'h00010 + 20'(k), 12'h020 + 12'(k));
    for (int k = 0; k < 5; k++) begin
      op(1, 0, 1, 0, {20'h00010 + 20'(k), 12'h000}, '0);
      check($sformatf("rr_page%0d_tlb_miss", k), tlb_miss_o, (k == 0));
    end

    op(1, 0, 1, 0, 32'h0001_1000, '0);
    check("pre_reset_ready", ready_o, 1'b1);
    do_reset();
    op(1, 0, 1, 0, 32'h0001_1000, '0);
    check("post_reset_tlb_miss", tlb_miss_o, 1'b1);
    op(1, 0, 1, 1, 32'h0000_5000, '0);
    check("post_reset_kernel_miss", miss_o, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clock); #1;
      reset_n              = ($urandom_range(0, 499) != 0);
      access_i             = ($urandom_range(0, 3) != 0);
      write_i              = 1'($urandom_range(0, 1));
      word_i               = 1'($urandom_range(0, 1));
      privilege_i          = ($urandom_range(0, 3) == 0);
      virtual_address_i    = {17'h0, 3'($urandom_range(0, 7)), 12'($urandom) & 12'h3FF};
      write_data_i         = $urandom;
      tlb_write_enable_i   = ($urandom_range(0, 7) == 0);
      tlb_w_virtual_page_i = {17'h0, 3'($urandom_range(0, 7))};
      tlb_w_phys_page_i    = 12'($urandom_range(0, 3));
      fill_valid_i         = 1'($urandom_range(0, 1));
      fill_line_i          = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clock); #1;
    reset_n = 1'b1; access_i = 1'b0; tlb_write_enable_i = 1'b0; fill_valid_i = 1'b0;
    @(negedge clock); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
